// File: rtl/sequencer_pattern_input_pkg.sv
// Shared constants for the step-sequencer pattern input block.
// Register map, status bit positions and debounce default.
package sequencer_pattern_input_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  localparam logic [1:0] ADDR_PATTERN = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_KEYS    = 2'd2;

  localparam int EVT_BIT = 0;
  localparam int CLR_BIT = 1;

endpackage

// File: rtl/key_debouncer.sv
// One button: 2-flop synchronizer, hold-time debouncer
// and a registered one-cycle pulse on each accepted press.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             db_q;
  logic             db_d;
  logic             rise_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db_q   <= 1'b0;
      db_d   <= 1'b0;
      rise_q <= 1'b0;
      cnt    <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      db_d   <= db_q;
      rise_q <= db_q & ~db_d;
      // any return to the accepted level restarts the hold count
      if (s2 == db_q) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db_q <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign db   = db_q;
  assign rise = rise_q;

endmodule

// File: rtl/sequencer_pattern_input.sv
// Step buttons to 8-bit step pattern, with clear-all,
// sticky event flag and a small processor register port.
module sequencer_pattern_input
  import sequencer_pattern_input_pkg::*;
#(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] btn_in,
  input  logic              clr_btn,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [N_KEYS-1:0] data_in,
  output logic [N_KEYS-1:0] data_out,
  output logic [N_KEYS-1:0] pattern_out,
  output logic              evt
);

  logic [N_KEYS:0]   raw;
  logic [N_KEYS:0]   db;
  logic [N_KEYS:0]   rise;
  logic [N_KEYS-1:0] key_rise;
  logic              clr_rise;
  logic              wr_pat;
  logic              rd_stat;
  logic [N_KEYS-1:0] pattern;
  logic              evt_q;

  // index N_KEYS is the clear-all button
  assign raw = {clr_btn, btn_in};

  for (genvar i = 0; i <= N_KEYS; i++) begin : g_deb
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .db   (db[i]),
      .rise (rise[i])
    );
  end

  assign key_rise = rise[N_KEYS-1:0];
  assign clr_rise = rise[N_KEYS];
  assign wr_pat   = sel & we & (addr == ADDR_PATTERN);
  assign rd_stat  = sel & ~we & (addr == ADDR_STATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
      evt_q   <= 1'b0;
    end else begin
      if (wr_pat) begin
        pattern <= data_in;
      end else if (clr_rise) begin
        pattern <= '0;
      end else begin
        pattern <= pattern ^ key_rise;
      end
      // a press in the read cycle must not be lost
      if (|rise) begin
        evt_q <= 1'b1;
      end else if (rd_stat) begin
        evt_q <= 1'b0;
      end
    end
  end

  always_comb begin
    data_out = '0;
    unique case (addr)
      ADDR_PATTERN: data_out = pattern;
      ADDR_STATUS: begin
        data_out[EVT_BIT] = evt_q;
        data_out[CLR_BIT] = db[N_KEYS];
      end
      ADDR_KEYS: data_out = db[N_KEYS-1:0];
      default: data_out = '0;
    endcase
  end

  assign pattern_out = pattern;
  assign evt         = evt_q;

endmodule

// File: tb/tb_sequencer_pattern_input.sv
// Bench for sequencer_pattern_input with a short debounce.
// Reference model: hold-window debounce over sampled inputs.
module tb_sequencer_pattern_input;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] btn_in = '0;
  logic       clr_btn = 1'b0;
  logic       sel = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic [7:0] pattern_out;
  logic       evt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sequencer_pattern_input #(
    .N_KEYS         (8),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .clr_btn    (clr_btn),
    .sel        (sel),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .pattern_out(pattern_out),
    .evt        (evt)
  );

  // model: raw samples delayed two edges, a level is accepted
  // once the last D delayed samples all disagree with it
  logic [8:0] m_r1, m_r2, m_db, m_db_d, m_rise;
  logic [8:0] m_win [D];
  logic [7:0] m_pat;
  logic       m_evt;

  task automatic model_reset();
    m_r1 = '0; m_r2 = '0; m_db = '0; m_db_d = '0;
    m_rise = '0; m_pat = '0; m_evt = 1'b0;
    for (int k = 0; k < D; k++) m_win[k] = '0;
  endtask

  function automatic logic [7:0] model_read(logic [1:0] a);
    case (a)
      2'd0: return m_pat;
      2'd1: return {6'b0, m_db[8], m_evt};
      2'd2: return m_db[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    logic [8:0] in_s;
    logic [8:0] flip;
    logic       wr0, rds;
    logic [7:0] din;
    in_s = {clr_btn, btn_in};
    wr0  = sel && we && addr == 2'd0;
    rds  = sel && !we && addr == 2'd1;
    din  = data_in;
    @(posedge clk);
    for (int k = D - 1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = m_r2;
    flip = '1;
    for (int k = 0; k < D; k++) flip &= (m_win[k] ^ m_db);
    if (wr0) m_pat = din;
    else if (m_rise[8]) m_pat = 8'h00;
    else m_pat = m_pat ^ m_rise[7:0];
    if (|m_rise) m_evt = 1'b1;
    else if (rds) m_evt = 1'b0;
    m_rise = m_db & ~m_db_d;
    m_db_d = m_db;
    m_db = m_db ^ flip;
    m_r2 = m_r1;
    m_r1 = in_s;
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_status_once();
    sel = 1'b1; we = 1'b0; addr = 2'd1;
    tick();
    sel = 1'b0;
  endtask

  task automatic test_reset();
    btn_in = 8'hFF;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pattern_out !== 8'h00 || evt !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: pattern=%h evt=%b want 00 0",
               pattern_out, evt);
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      checks++;
      if (data_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_read%0d: got %h want 00", a, data_out);
      end
    end
    addr = 2'd0;
    rst_n = 1'b1;
    ticks(7);
    checks++;
    if (pattern_out !== 8'h00) begin
      errors++;
      $display("FAIL held_early: got %h want 00", pattern_out);
    end
    tick();
    checks++;
    if (pattern_out !== 8'hFF || m_pat !== 8'hFF) begin
      errors++;
      $display("FAIL held_accept: got %h model %h want ff",
               pattern_out, m_pat);
    end
    btn_in = 8'h00;
    ticks(10);
  endtask

  task automatic test_key_toggle();
    sel = 1'b1; we = 1'b1; addr = 2'd0; data_in = 8'h00;
    tick();
    sel = 1'b0; we = 1'b0;
    read_status_once();
    for (int r = 0; r < 2; r++) begin
      btn_in[3] = 1'b1;
      ticks(10);
      btn_in[3] = 1'b0;
      ticks(10);
      checks++;
      if (pattern_out !== (r == 0 ? 8'h08 : 8'h00) ||
          pattern_out !== m_pat || evt !== 1'b1) begin
        errors++;
        $display("FAIL key_toggle%0d: pattern=%h evt=%b want %h 1",
                 r, pattern_out, evt, m_pat);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] p0;
    read_status_once();
    p0 = pattern_out;
    for (int r = 0; r < 5; r++) begin
      btn_in[0] = 1'b1;
      ticks(3);
      btn_in[0] = 1'b0;
      ticks(3);
    end
    ticks(4);
    addr = 2'd2;
    #1;
    checks++;
    if (pattern_out !== p0 || evt !== 1'b0 ||
        data_out !== 8'h00 || m_pat !== p0) begin
      errors++;
      $display("FAIL glitch: pattern=%h evt=%b keys=%h want %h 0 00",
               pattern_out, evt, data_out, p0);
    end
  endtask

  task automatic test_status_read();
    btn_in[1] = 1'b1;
    ticks(10);
    btn_in[1] = 1'b0;
    ticks(10);
    sel = 1'b1; we = 1'b0; addr = 2'd1;
    #1;
    checks++;
    if (data_out !== 8'h01) begin
      errors++;
      $display("FAIL status_in_read: got %h want 01", data_out);
    end
    tick();
    sel = 1'b0;
    checks++;
    if (data_out !== 8'h00 || evt !== 1'b0) begin
      errors++;
      $display("FAIL status_after: got %h evt=%b want 00 0",
               data_out, evt);
    end
    btn_in[2] = 1'b1;
    ticks(7);
    sel = 1'b1; we = 1'b0; addr = 2'd1;
    tick();
    sel = 1'b0;
    checks++;
    if (evt !== 1'b1 || m_evt !== 1'b1) begin
      errors++;
      $display("FAIL status_set_wins: evt=%b model=%b want 1",
               evt, m_evt);
    end
    btn_in[2] = 1'b0;
    ticks(10);
  endtask

  task automatic test_priority();
    read_status_once();
    clr_btn = 1'b1;
    btn_in[5] = 1'b1;
    ticks(7);
    sel = 1'b1; we = 1'b1; addr = 2'd0; data_in = 8'hA5;
    tick();
    sel = 1'b0; we = 1'b0;
    checks++;
    if (pattern_out !== 8'hA5 || evt !== 1'b1) begin
      errors++;
      $display("FAIL prio_write: pattern=%h evt=%b want a5 1",
               pattern_out, evt);
    end
    addr = 2'd1;
    #1;
    checks++;
    if (data_out !== 8'h03) begin
      errors++;
      $display("FAIL prio_clr_db: got %h want 03", data_out);
    end
    clr_btn = 1'b0;
    btn_in[5] = 1'b0;
    ticks(10);
    clr_btn = 1'b1;
    ticks(10);
    clr_btn = 1'b0;
    ticks(10);
    checks++;
    if (pattern_out !== 8'h00 || m_pat !== 8'h00) begin
      errors++;
      $display("FAIL prio_clear: got %h want 00", pattern_out);
    end
  endtask

  task automatic test_simultaneous();
    btn_in = 8'h81;
    ticks(10);
    btn_in = 8'h00;
    ticks(10);
    checks++;
    if (pattern_out !== 8'h81 || m_pat !== 8'h81) begin
      errors++;
      $display("FAIL simul_keys: got %h want 81", pattern_out);
    end
    read_status_once();
    for (int a = 1; a < 4; a++) begin
      sel = 1'b1; we = 1'b1; addr = 2'(a); data_in = 8'hFF;
      tick();
    end
    sel = 1'b0; we = 1'b0;
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a);
      #1;
      checks++;
      if (data_out !== (a == 0 ? 8'h81 : 8'h00)) begin
        errors++;
        $display("FAIL ro_write%0d: got %h want %h",
                 a, data_out, (a == 0 ? 8'h81 : 8'h00));
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 120; seg++) begin
      btn_in  = 8'($urandom);
      clr_btn = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(1, 9);
      for (int c = 0; c < hold; c++) begin
        sel     = ($urandom_range(0, 3) == 0);
        we      = 1'($urandom);
        addr    = 2'($urandom);
        data_in = 8'($urandom);
        #1;
        checks++;
        if (data_out !== model_read(addr) ||
            pattern_out !== m_pat || evt !== m_evt) begin
          errors++;
          $display("FAIL rand: addr=%0d rd=%h pat=%h evt=%b want %h %h %b",
                   addr, data_out, pattern_out, evt,
                   model_read(addr), m_pat, m_evt);
        end
        tick();
      end
    end
    sel = 1'b0; we = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_key_toggle();
    test_glitch();
    test_status_read();
    test_priority();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequencer_pattern_input.md
Name: sequencer_pattern_input

Overview:
- Front end of the step sequencer: turns the user's 8 step buttons into the 8-bit step pattern that drives the sequencer's per-step sound gating and LED overlay.
- Synchronizes and debounces raw buttons, toggles a step bit on each press, and supports a clear-all button.
- Exposes pattern, status and key state to picoversat over a small select/write-enable register port.
- Raises a sticky event flag the processor polls.

Parameters:
- N_KEYS, 8, number of step buttons/pattern bits (bus widths below assume 8).
- DEBOUNCE_CYCLES, 1000000, cycles an input must hold a new level before it is accepted (10 ms at 100 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  8  raw step buttons, active-high, asynchronous to clk.
- clr_btn  in  1  raw clear-all button, active-high, asynchronous.
- sel  in  1  processor select for this peripheral.
- we  in  1  write enable, qualified by sel.
- addr  in  2  register address.
- data_in  in  8  processor write data.
- data_out  out  8  processor read data, combinational from addr.
- pattern_out  out  8  current step pattern to the sequencer's kbd_in.
- evt  out  1  sticky event flag, level.

Behaviour:
- Reset (rst_n low, async) clears:
  - sync flops, debounced states, debounce counters and the pattern register (pattern_out=0x00).
  - evt=0; data_out reads 0x00 at every address.
- Sync: each raw input passes through 2 flops (s1, s2) before use.
- Debounce, per input, with debounced state db and counter cnt:
  - s2==db: cnt<=0.
  - s2!=db and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s2!=db and cnt==DEBOUNCE_CYCLES-1: db<=s2, cnt<=0.
  - db therefore changes exactly DEBOUNCE_CYCLES cycles after s2 first differs. Any shorter glitch restarts the count and leaves db unchanged.
- Press detect: rising edge of db (registered db_d), a one-cycle pulse. Releases generate nothing.
- Key press i: pattern[i] <= ~pattern[i] on the cycle after the db rise. Multiple keys rising in the same cycle all toggle.
- Clear press (clr_db rising): pattern <= 0x00.
- Pattern priority in one cycle, highest first:
  1. processor write to addr 0.
  2. clear press.
  3. key toggles.
  A lower-priority event in the same cycle is discarded, not deferred.
- Register map:
  - addr 0: pattern, R/W.
  - addr 1: status, RO, {6'b0, clr_db, evt}.
  - addr 2: debounced key state db[7:0], RO.
  - addr 3: reads 0x00.
  - Writes to addr 1..3 are ignored.
- Write: sel&we&addr==0 -> pattern<=data_in next edge; pattern_out updates the same edge.
- evt:
  - Set by any key press or clear press.
  - Cleared on the clock edge of a read of status (sel & !we & addr==1); data_out during that read still shows evt=1.
  - Set and clear in the same cycle -> set wins.
  - Processor writes do not set evt.
- Reset mid-debounce or mid-press: everything returns to reset values. A button held through reset is accepted as pressed DEBOUNCE_CYCLES+2 cycles after rst_n rises and toggles its bit once.
- Counters never wrap: cnt is bounded by DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package/header holds:
  - Address constants ADDR_PATTERN=0, ADDR_STATUS=1, ADDR_KEYS=2.
  - Status bit indices EVT_BIT=0, CLR_BIT=1.
  - Default DEBOUNCE_CYCLES.
- One sub-module, key_debouncer (2-flop sync + counter + db + rising-edge pulse, parameterized by DEBOUNCE_CYCLES/CNT_W). It is instantiated N_KEYS+1 times by generate.
- Top level holds the pattern register, evt and the read mux.

Test Plan (DEBOUNCE_CYCLES=4 overridden):
- Reset: rst_n=0 with btn_in=0xFF -> pattern_out=0x00, evt=0, all reads 0x00. Release reset, hold buttons -> pattern_out=0xFF exactly 4+2+2 cycles after rst_n rises.
- Key toggle: btn_in[3] held high 10 cycles then low -> pattern_out=0x08, evt=1. A second identical press -> pattern_out=0x00.
- Glitch rejection: btn_in[0] high for 3 synced cycles, low, repeated 5 times -> pattern_out unchanged, evt=0, addr 2 reads 0x00.
- Status read: after a press, read addr 1 -> data_out=0x01 in the read cycle, then 0x00. Press landing in the read cycle -> evt stays 1.
- Priority: write 0xA5 to addr 0 in the same cycle as a clear press and a key-5 press -> pattern_out=0xA5. A later clear press alone -> 0x00.
- Simultaneous keys: btn_in 0x00->0x81 together -> both bits toggle in one cycle, pattern_out=0x81. Writes to addr 1/2 leave all registers unchanged.
